alu_cmd_sched: RTL and testbench
================================

ALU_CMD_SCHED -- requirements
Module: alu_cmd_sched

Interface
REQ-001 SHALL have parameters: DEPTH, default 4, command FIFO entries (power of 2); TIMEOUT, default 15, max WAIT cycles before abort.
REQ-002 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_opcode  in  4  ALU opcode.
- cmd_a  in  16  operand A.
- cmd_b  in  16  operand B.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready.
- rsp_data  out  16  ALU result, or 0 on error.
- rsp_err  out  1  illegal opcode, timeout or power abort.
- alu_pwr_en  in  1  ALU power-domain enable.
- alu_start  out  1  ALU start strobe.
- alu_opcode  out  4  ALU opcode.
- alu_a  out  16  ALU operand A.
- alu_b  out  16  ALU operand B.
- alu_result  in  16  registered ALU result.
- alu_result_valid  in  1  ALU completion (combinational on ALU side).
- alu_busy  in  1  ALU multi-cycle op in progress.

Function
REQ-003 SHALL buffer commands {opcode,A,B} in a DEPTH-entry FIFO; cmd_ready = !full; push and pop in the same cycle when not full leave the count unchanged; there is no push when full.
REQ-004 SHALL use FSM states IDLE, ISSUE, WAIT, CAPTURE, RESP.
REQ-005 IDLE: when the FIFO is non-empty, alu_pwr_en=1 and alu_busy=0, SHALL pop the head into the operand registers; opcode > 4'b1001 goes to RESP with rsp_err=1 and rsp_data=0, otherwise to ISSUE.
REQ-006 ISSUE: SHALL assert alu_start for exactly this one cycle; if alu_result_valid=1, go to CAPTURE, else go to WAIT.
REQ-007 alu_opcode, alu_a and alu_b SHALL be driven from the operand registers and held stable from ISSUE through CAPTURE.
REQ-008 WAIT: SHALL count cycles starting at 0. On alu_result_valid, go to CAPTURE. Else, if alu_pwr_en=0, go to RESP with err=1. Else, if count==TIMEOUT, go to RESP with err=1.
REQ-009 CAPTURE: SHALL register rsp_data <= alu_result and rsp_err <= 0, then go to RESP.
REQ-010 RESP: SHALL hold rsp_valid=1 with stable rsp_data and rsp_err until rsp_ready, then go to IDLE.
REQ-011 Latency from pop cycle T to first rsp_valid cycle SHALL be: ops 0-7 T+3; MUL (1000) T+8; DIV (1001) T+12; illegal opcode T+1.
REQ-012 Commands SHALL be issued strictly in order with at most one outstanding; alu_start SHALL never assert while alu_busy=1 or alu_pwr_en=0.
REQ-013 alu_pwr_en=0 in any state other than WAIT SHALL only stall IDLE pops; ISSUE is not entered without power.

Reset
REQ-014 On rst=1 at a clock edge SHALL: FSM to IDLE, FIFO empty, WAIT counter 0, rsp_valid=0, rsp_data=0, rsp_err=0, alu_start=0, alu_opcode/alu_a/alu_b=0.
REQ-015 Reset mid-operation SHALL discard the in-flight command and all queued commands with no response generated.
REQ-016 cmd_ready SHALL be 0 while rst=1 and 1 on the first cycle after reset.

Structure
REQ-017 The shared package alu_pkg SHALL hold the opcode constants (ADD..XNOR, MUL=4'b1000, DIV=4'b1001), the scheduler state enum, and the MUL/DIV latency constants.
REQ-018 The FIFO SHALL be the sub-module alu_cmd_fifo (parameterised width and depth, registered count, full/empty flags).

Verification
REQ-019 The bench SHALL cover:
- ADD A=16'h0003, B=16'h0004, rsp_ready=1 -> rsp_valid at T+3, rsp_data=16'h0007, err=0.
- MUL 3*4 -> rsp_data=16'd12 at T+8; DIV 100/7 -> 16'd14 at T+12; DIV by 0 -> 16'd0, err=0.
- Opcode 4'b1100 -> rsp_err=1, rsp_data=0 at T+1; alu_start never asserted.
- Push 5 commands back-to-back with rsp_ready=0 -> cmd_ready drops after the 4th accepted command and the first response is held stable; releasing rsp_ready drains the results in order.
- alu_pwr_en dropped during a DIV WAIT -> RESP with err=1; a later command issues only after alu_pwr_en=1.
- rst pulsed during a MUL WAIT -> all outputs at reset values next cycle, FIFO empty, no response.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the ALU command scheduler: ALU opcode encodings,
// the scheduler state enum and the fixed latencies of the multi-cycle ALU
// operations.
package alu_pkg;

  // Single-cycle ALU operations.
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_NAND = 4'b0101;
  localparam logic [3:0] OP_NOR  = 4'b0110;
  localparam logic [3:0] OP_XNOR = 4'b0111;

  // Multi-cycle ALU operations. Anything above OP_DIV is illegal.
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_DIV  = 4'b1001;

  // Cycles from the alu_start strobe to alu_result_valid for the
  // multi-cycle operations.
  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 9;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    CAPTURE,
    RESP
  } sched_state_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo
// Synchronous FIFO holding pending ALU commands.
// Ports:
//   clk, rst      clock, synchronous active-high reset (empties the FIFO)
//   push, wdata   write request and data; ignored while full
//   pop, rdata    read request and head-of-queue data; ignored while empty
//   full, empty   occupancy flags derived from the registered count
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module alu_cmd_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNTW-1:0]  count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNTW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage needs no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // A simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + CNTW'(1);
      end else if (do_pop && !do_push) begin
        count <= count - CNTW'(1);
      end
    end
  end

endmodule

// File: rtl/alu_cmd_sched.sv
// alu_cmd_sched
// Queues ALU commands and issues them one at a time, in order, to an ALU in
// a switchable power domain, returning one response per command.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cmd_valid/cmd_ready           command handshake; cmd_opcode, cmd_a, cmd_b
//   rsp_valid/rsp_ready           response handshake; rsp_data, rsp_err
//   alu_pwr_en                    ALU power-domain enable
//   alu_start, alu_opcode/a/b     request to the ALU
//   alu_result, alu_result_valid  ALU completion
//   alu_busy                      ALU still running a multi-cycle op
module alu_cmd_sched #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_opcode,
  input  logic [15:0] cmd_a,
  input  logic [15:0] cmd_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  input  logic        alu_pwr_en,
  output logic        alu_start,
  output logic [3:0]  alu_opcode,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  input  logic [15:0] alu_result,
  input  logic        alu_result_valid,
  input  logic        alu_busy
);

  import alu_pkg::*;

  localparam int CW = $clog2(TIMEOUT + 1);

  sched_state_t  state;
  sched_state_t  next_state;
  logic          fifo_full;
  logic          fifo_empty;
  logic [35:0]   fifo_rdata;
  logic          push;
  logic          pop;
  logic          head_illegal;
  logic          abort;
  logic [3:0]    op_q;
  logic [15:0]   a_q;
  logic [15:0]   b_q;
  logic [CW-1:0] wait_cnt;

  // Held low during reset so nothing is accepted into a FIFO being cleared.
  assign cmd_ready    = !fifo_full && !rst;
  assign push         = cmd_valid && cmd_ready;
  assign head_illegal = (fifo_rdata[35:32] > OP_DIV);
  assign rsp_valid    = (state == RESP);
  assign alu_opcode   = op_q;
  assign alu_a        = a_q;
  assign alu_b        = b_q;

  alu_cmd_fifo #(
    .WIDTH (36),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({cmd_opcode, cmd_a, cmd_b}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Next-state logic. alu_start is also qualified in ISSUE so that a power
  // drop or a busy ALU in that cycle stalls the issue instead of starting.
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    alu_start  = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty && alu_pwr_en && !alu_busy) begin
          pop        = 1'b1;
          next_state = head_illegal ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        if (alu_pwr_en && !alu_busy) begin
          alu_start  = 1'b1;
          next_state = alu_result_valid ? CAPTURE : WAIT;
        end
      end
      WAIT: begin
        if (alu_result_valid) begin
          next_state = CAPTURE;
        end else if (!alu_pwr_en || (wait_cnt == CW'(TIMEOUT))) begin
          abort      = 1'b1;
          next_state = RESP;
        end
      end
      CAPTURE: next_state = RESP;
      RESP: begin
        if (rsp_ready) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State, operand, wait-counter and response registers. Errors (illegal
  // opcode, timeout, power loss) all report data 0 with the error flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      wait_cnt <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      state <= next_state;
      if (pop) begin
        op_q <= fifo_rdata[35:32];
        a_q  <= fifo_rdata[31:16];
        b_q  <= fifo_rdata[15:0];
        if (head_illegal) begin
          rsp_data <= '0;
          rsp_err  <= 1'b1;
        end
      end
      if (state == ISSUE) begin
        wait_cnt <= '0;
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt + CW'(1);
      end
      if (abort) begin
        rsp_data <= '0;
        rsp_err  <= 1'b1;
      end
      if (state == CAPTURE) begin
        rsp_data <= alu_result;
        rsp_err  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_sched.sv
// tb_alu_cmd_sched
// Self-checking bench for alu_cmd_sched. A small behavioural ALU stands in
// for the power-gated ALU: single-cycle ops raise alu_result_valid in the
// start cycle, MUL/DIV raise it a fixed number of cycles after start, and
// losing power cancels any operation in progress.
module tb_alu_cmd_sched;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_opcode;
  logic [15:0] cmd_a;
  logic [15:0] cmd_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic        alu_pwr_en;
  logic        alu_start;
  logic [3:0]  alu_opcode;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [15:0] alu_result;
  logic        alu_result_valid;
  logic        alu_busy;

  int total = 0;
  int bad = 0;
  int start_count = 0;
  int start_violations = 0;

  logic [4:0]  model_cnt;
  logic [15:0] model_res;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] data;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  always #5 clk = ~clk;

  alu_cmd_sched #(.DEPTH(4), .TIMEOUT(15)) dut (
    .clk              (clk),
    .rst              (rst),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_opcode       (cmd_opcode),
    .cmd_a            (cmd_a),
    .cmd_b            (cmd_b),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_data         (rsp_data),
    .rsp_err          (rsp_err),
    .alu_pwr_en       (alu_pwr_en),
    .alu_start        (alu_start),
    .alu_opcode       (alu_opcode),
    .alu_a            (alu_a),
    .alu_b            (alu_b),
    .alu_result       (alu_result),
    .alu_result_valid (alu_result_valid),
    .alu_busy         (alu_busy)
  );

  // Behavioural ALU function.
  function automatic logic [15:0] alu_func(input logic [3:0] op,
                                           input logic [15:0] a,
                                           input logic [15:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_NAND: return ~(a & b);
      OP_NOR:  return ~(a | b);
      OP_XNOR: return ~(a ^ b);
      OP_MUL:  return 16'(a * b);
      OP_DIV:  return (b == 16'h0) ? 16'h0 : a / b;
      default: return 16'h0;
    endcase
  endfunction

  // ALU stand-in: result registered at the start edge, completion flag
  // combinational in the start cycle for single-cycle ops.
  assign alu_busy         = (model_cnt != 5'd0);
  assign alu_result       = model_res;
  assign alu_result_valid = (alu_start && (alu_opcode <= OP_XNOR)) || (model_cnt == 5'd1);

  always @(posedge clk) begin
    if (rst) begin
      model_cnt <= 5'd0;
      model_res <= 16'h0;
    end else if (!alu_pwr_en) begin
      model_cnt <= 5'd0;
    end else if (alu_start) begin
      model_res <= alu_func(alu_opcode, alu_a, alu_b);
      model_cnt <= (alu_opcode == OP_MUL) ? 5'(MUL_LAT) :
                   (alu_opcode == OP_DIV) ? 5'(DIV_LAT) : 5'd0;
    end else if (model_cnt != 5'd0) begin
      model_cnt <= model_cnt - 5'd1;
    end
  end

  // Count start strobes and any strobe issued to a busy or unpowered ALU.
  always @(negedge clk) begin
    if (alu_start) begin
      start_count++;
      if (alu_busy || !alu_pwr_en) start_violations++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Offer one command and hold it until accepted (bounded); returns one
  // cycle after the accepting edge.
  task automatic apply_stimulus(input logic [3:0] op, input logic [15:0] a,
                                input logic [15:0] b);
    int n = 0;
    cmd_valid  = 1'b1;
    cmd_opcode = op;
    cmd_a      = a;
    cmd_b      = b;
    while (!cmd_ready && n < 50) begin
      step();
      n++;
    end
    check_output("push_accepted", 32'(cmd_ready), 32'd1);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int cycles);
    cycles = 0;
    while (!rsp_valid && cycles < 60) begin
      step();
      cycles++;
    end
  endtask

  initial begin
    int n;
    int s0;
    int seen;

    vecs[0] = '{OP_ADD,  16'h0003, 16'h0004, 16'h0007, 1'b0, 3};
    vecs[1] = '{OP_SUB,  16'h0010, 16'h0001, 16'h000F, 1'b0, 3};
    vecs[2] = '{OP_AND,  16'hF0F0, 16'hFF00, 16'hF000, 1'b0, 3};
    vecs[3] = '{OP_OR,   16'h00F0, 16'h0F00, 16'h0FF0, 1'b0, 3};
    vecs[4] = '{OP_XNOR, 16'h00FF, 16'h0F0F, 16'hF00F, 1'b0, 3};
    vecs[5] = '{OP_MUL,  16'h0003, 16'h0004, 16'd12,   1'b0, 8};
    vecs[6] = '{OP_DIV,  16'd100,  16'd7,    16'd14,   1'b0, 12};
    vecs[7] = '{OP_DIV,  16'd5,    16'd0,    16'd0,    1'b0, 12};
    vecs[8] = '{4'b1100, 16'h1234, 16'h5678, 16'h0000, 1'b1, 1};
    vecs[9] = '{4'b1111, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1};

    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_opcode = 4'h0;
    cmd_a      = 16'h0;
    cmd_b      = 16'h0;
    rsp_ready  = 1'b0;
    alu_pwr_en = 1'b1;

    // Reset state.
    step();
    step();
    check_output("ready_in_reset", 32'(cmd_ready), 32'd0);
    rst = 1'b0;
    step();
    check_output("ready_after_reset", 32'(cmd_ready), 32'd1);
    check_output("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_output("rst_rsp_data", 32'(rsp_data), 32'd0);
    check_output("rst_rsp_err", 32'(rsp_err), 32'd0);
    check_output("rst_alu_start", 32'(alu_start), 32'd0);
    check_output("rst_alu_opcode", 32'(alu_opcode), 32'd0);

    // Single commands: latency from pop, data, error, start strobe count.
    rsp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      s0 = start_count;
      apply_stimulus(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_rsp(n);
      $display("[TB] vector %0d op=%b latency=%0d", i, vecs[i].op, n);
      check_output("vec_rsp_valid", 32'(rsp_valid), 32'd1);
      check_output("vec_latency", 32'(n), 32'(vecs[i].lat));
      check_output("vec_rsp_data", 32'(rsp_data), 32'(vecs[i].data));
      check_output("vec_rsp_err", 32'(rsp_err), 32'(vecs[i].err));
      check_output("vec_start_count", 32'(start_count - s0), vecs[i].err ? 32'd0 : 32'd1);
      step();
    end

    // Fill the FIFO with the ALU unpowered so nothing pops, then let it run
    // with rsp_ready low and check the first response is held.
    rsp_ready  = 1'b0;
    alu_pwr_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(OP_ADD, 16'(i + 1), 16'h0100);
    end
    check_output("full_ready_low", 32'(cmd_ready), 32'd0);
    step();
    check_output("full_ready_still_low", 32'(cmd_ready), 32'd0);
    alu_pwr_en = 1'b1;
    apply_stimulus(OP_ADD, 16'h0005, 16'h0100);
    wait_rsp(n);
    check_output("held_rsp_valid", 32'(rsp_valid), 32'd1);
    for (int k = 0; k < 4; k++) begin
      step();
      check_output("held_valid_stable", 32'(rsp_valid), 32'd1);
      check_output("held_data_stable", 32'(rsp_data), 32'h0101);
    end
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_rsp(n);
      check_output("drain_valid", 32'(rsp_valid), 32'd1);
      check_output("drain_data", 32'(rsp_data), 32'(16'h0101 + 16'(i)));
      check_output("drain_err", 32'(rsp_err), 32'd0);
      step();
    end

    // Power drop while a DIV is waiting aborts it with an error.
    apply_stimulus(OP_DIV, 16'd100, 16'd7);
    repeat (4) step();
    alu_pwr_en = 1'b0;
    wait_rsp(n);
    check_output("pwr_abort_valid", 32'(rsp_valid), 32'd1);
    check_output("pwr_abort_latency", 32'(n), 32'd1);
    check_output("pwr_abort_err", 32'(rsp_err), 32'd1);
    check_output("pwr_abort_data", 32'(rsp_data), 32'd0);
    step();
    s0 = start_count;
    apply_stimulus(OP_ADD, 16'h0020, 16'h0002);
    repeat (6) step();
    check_output("no_start_unpowered", 32'(start_count - s0), 32'd0);
    check_output("no_rsp_unpowered", 32'(rsp_valid), 32'd0);
    alu_pwr_en = 1'b1;
    wait_rsp(n);
    check_output("repower_valid", 32'(rsp_valid), 32'd1);
    check_output("repower_data", 32'(rsp_data), 32'h0022);
    check_output("repower_err", 32'(rsp_err), 32'd0);
    check_output("repower_start", 32'(start_count - s0), 32'd1);
    step();

    // Reset during a MUL wait with another command queued behind it.
    apply_stimulus(OP_MUL, 16'h0003, 16'h0004);
    apply_stimulus(OP_ADD, 16'h0001, 16'h0001);
    repeat (3) step();
    rst = 1'b1;
    step();
    check_output("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_output("midrst_rsp_data", 32'(rsp_data), 32'd0);
    check_output("midrst_rsp_err", 32'(rsp_err), 32'd0);
    check_output("midrst_alu_start", 32'(alu_start), 32'd0);
    check_output("midrst_alu_opcode", 32'(alu_opcode), 32'd0);
    check_output("midrst_alu_a", 32'(alu_a), 32'd0);
    check_output("midrst_alu_b", 32'(alu_b), 32'd0);
    check_output("midrst_ready", 32'(cmd_ready), 32'd0);
    rst = 1'b0;
    step();
    check_output("postrst_ready", 32'(cmd_ready), 32'd1);
    s0   = start_count;
    seen = 0;
    repeat (20) begin
      step();
      if (rsp_valid) seen++;
    end
    check_output("postrst_no_rsp", 32'(seen), 32'd0);
    check_output("postrst_no_start", 32'(start_count - s0), 32'd0);

    check_output("start_while_busy_or_off", 32'(start_violations), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
